// File: rtl/mux_arb_stage_if.sv
// -----------------------------------------------------------------------------
// mux_arb_stage_if
// Handshake bundle for mux_arb_stage: two arbitrated input channels (I1, I0)
// and the buffered output channel.
//   slave  : the arbitration stage (consumes inX_*, produces out_*)
//   master : the surrounding environment (produces inX_*, consumes out_*)
// Signals:
//   in1_valid/in1_data/in1_ready : channel 1 handshake
//   in0_valid/in0_data/in0_ready : channel 0 handshake
//   out_valid/out_data/out_ready : buffer head handshake
// -----------------------------------------------------------------------------
interface mux_arb_if #(
  parameter int N = 2
);
  logic       in1_valid;
  logic [N:0] in1_data;
  logic       in1_ready;
  logic       in0_valid;
  logic [N:0] in0_data;
  logic       in0_ready;
  logic       out_valid;
  logic [N:0] out_data;
  logic       out_ready;

  modport slave (
    input  in1_valid, in1_data, in0_valid, in0_data, out_ready,
    output in1_ready, in0_ready, out_valid, out_data
  );

  modport master (
    output in1_valid, in1_data, in0_valid, in0_data, out_ready,
    input  in1_ready, in0_ready, out_valid, out_data
  );
endinterface

// File: rtl/mux_arb_stage.sv
// -----------------------------------------------------------------------------
// mux_arb_stage
// Arbitrated source stage for the 2:1 data mux path. Each cycle it picks one of
// two valid/ready input channels, writes the winner's data into a 2-entry
// output FIFO and records which channel won (sel). Saturating per-channel grant
// counters expose how often each channel was accepted.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   bus          mux_arb_if.slave (inX valid/data/ready, out valid/data/ready)
//   sel          channel of the most recent accepted transfer (1 = I1)
//   cnt1, cnt0   saturating counts of accepted I1 / I0 transfers
//
// Configuration macro: MUX_ARB_RR_EN
//   defined   : round-robin, priority passes to the loser after each push
//   undefined : fixed priority, I1 wins whenever both channels are valid
// -----------------------------------------------------------------------------
module mux_arb_stage #(
  parameter int N  = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  mux_arb_if.slave      bus,
  output logic          sel,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt0
);

  logic [N:0]    r_mem [2];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_count;
  logic          r_sel;
  logic [CW-1:0] r_cnt1;
  logic [CW-1:0] r_cnt0;

  logic          w_pri;    // 1 = I1 preferred when both channels are valid
  logic          w_pop;
  logic          w_space;
  logic          w_any;
  logic          w_win;    // winning channel, meaningful only when w_any
  logic          w_push;
  logic [N:0]    w_wdata;

`ifdef MUX_ARB_RR_EN
  logic r_pri;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pri <= 1'b1;
    end else if (w_push) begin
      r_pri <= ~w_win;
    end
  end

  assign w_pri = r_pri;
`else
  assign w_pri = 1'b1;
`endif

  // NOTE: every always_comb output is assigned on every path, so no latch is
  // inferred; new outputs added here must keep that property.
  always_comb begin
    w_any   = bus.in1_valid | bus.in0_valid;
    w_win   = bus.in1_valid & (~bus.in0_valid | w_pri);
    w_pop   = (r_count != 2'd0) & bus.out_ready;
    // A pop in the same cycle frees the slot the push is about to use.
    w_space = (r_count < 2'd2) | w_pop;
    // Readies are held low while reset is asserted even though the FIFO
    // already looks empty.
    w_push  = ~rst & w_any & w_space;
    w_wdata = w_win ? bus.in1_data : bus.in0_data;
  end

  assign bus.in1_ready = w_push & w_win;
  assign bus.in0_ready = w_push & ~w_win;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = r_mem[r_rd_ptr];

  assign sel  = r_sel;
  assign cnt1 = r_cnt1;
  assign cnt0 = r_cnt0;

  // NOTE: the data storage has no reset; out_data is only meaningful while
  // out_valid is high, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel  <= 1'b0;
      r_cnt1 <= '0;
      r_cnt0 <= '0;
    end else if (w_push) begin
      r_sel <= w_win;
      if (w_win && (r_cnt1 != '1)) begin
        r_cnt1 <= r_cnt1 + CW'(1);
      end
      if (!w_win && (r_cnt0 != '1)) begin
        r_cnt0 <= r_cnt0 + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_stage.sv
// -----------------------------------------------------------------------------
// tb_mux_arb_stage
// Directed scenarios with literal expectations, then randomized traffic and
// occasional asynchronous resets checked every cycle against a queue-based
// model of the stage. Built with CW = 2 so counter saturation is reached.
// -----------------------------------------------------------------------------
module tb_mux_arb_stage;

  localparam int N    = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          sel;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt0;

  mux_arb_if #(.N(N)) bus ();

  mux_arb_stage #(.N(N), .CW(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sel  (sel),
    .cnt1 (cnt1),
    .cnt0 (cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: FIFO as a queue, arbitration from the priority rules.
  // ---------------------------------------------------------------------------
  logic [N:0] m_q[$];
  int         m_sel;
  int         m_pri;
  int         m_cnt1;
  int         m_cnt0;

  function automatic int m_winner();
    if (bus.in1_valid && bus.in0_valid) return m_pri;
    if (bus.in1_valid) return 1;
    if (bus.in0_valid) return 0;
    return -1;
  endfunction

  function automatic bit m_push_now();
    bit pop;
    pop = (m_q.size() > 0) && bus.out_ready;
    return !rst && (m_winner() >= 0) && ((m_q.size() < 2) || pop);
  endfunction

  int m_w;
  bit m_pop;
  bit m_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_sel  = 0;
      m_pri  = 1;
      m_cnt1 = 0;
      m_cnt0 = 0;
    end else begin
      m_w    = m_winner();
      m_push = m_push_now();
      m_pop  = (m_q.size() > 0) && bus.out_ready;
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        m_q.push_back(m_w == 1 ? bus.in1_data : bus.in0_data);
        m_sel = m_w;
`ifdef MUX_ARB_RR_EN
        m_pri = 1 - m_w;
`endif
        if (m_w == 1 && m_cnt1 < CMAX) m_cnt1++;
        if (m_w == 0 && m_cnt0 < CMAX) m_cnt0++;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("m_out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("m_out_data", 32'(bus.out_data), 32'(m_q[0]));
    check("m_sel",  32'(sel),  32'(m_sel));
    check("m_cnt1", 32'(cnt1), 32'(m_cnt1));
    check("m_cnt0", 32'(cnt0), 32'(m_cnt0));
    check("m_in1_ready", 32'(bus.in1_ready), 32'(m_push_now() && m_winner() == 1));
    check("m_in0_ready", 32'(bus.in0_ready), 32'(m_push_now() && m_winner() == 0));
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v1, input logic [N:0] d1, input bit v0,
                       input logic [N:0] d0, input bit ordy);
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.out_ready = ordy;
  endtask

  logic [N:0] exp_seq [4];
  int         exp_sel [4];

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);

    // Reset then idle.
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sel",       32'(sel),           32'd0);
    check("rst_cnt1",      32'(cnt1),          32'd0);
    check("rst_cnt0",      32'(cnt0),          32'd0);
    check("rst_in1_ready", 32'(bus.in1_ready), 32'd0);
    check("rst_in0_ready", 32'(bus.in0_ready), 32'd0);

    // Single channel 0 transfer.
    drive(1'b0, '0, 1'b1, 3'b001, 1'b1);
    #1;
    check("single_in0_ready", 32'(bus.in0_ready), 32'd1);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    #1;
    check("single_out_valid", 32'(bus.out_valid), 32'd1);
    check("single_out_data",  32'(bus.out_data),  32'h1);
    check("single_sel",       32'(sel),           32'd0);
    check("single_cnt0",      32'(cnt0),          32'd1);
    tick();

    // Contention, out_ready held high.
`ifdef MUX_ARB_RR_EN
    exp_seq = '{3'b110, 3'b101, 3'b110, 3'b101};
    exp_sel = '{1, 0, 1, 0};
`else
    exp_seq = '{3'b110, 3'b110, 3'b110, 3'b110};
    exp_sel = '{1, 1, 1, 1};
`endif
    drive(1'b1, 3'b110, 1'b1, 3'b101, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont_out_data", 32'(bus.out_data), 32'(exp_seq[i]));
      check("cont_sel",      32'(sel),          32'(exp_sel[i]));
    end
`ifdef MUX_ARB_RR_EN
    check("cont_cnt1", 32'(cnt1), 32'd2);
    check("cont_cnt0", 32'(cnt0), 32'd3);
`else
    check("cont_cnt1", 32'(cnt1), 32'd3);
    check("cont_cnt0", 32'(cnt0), 32'd1);
`endif
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    repeat (2) tick();

    // Backpressure: two accepted, third blocked until a pop.
    drive(1'b1, 3'b010, 1'b0, '0, 1'b0);
    tick();
    bus.in1_data = 3'b011;
    tick();
    check("bp_in1_ready_full", 32'(bus.in1_ready), 32'd0);
    check("bp_head",           32'(bus.out_data),  32'h2);
    bus.in1_data  = 3'b100;
    bus.out_ready = 1'b1;
    #1;
    check("bp_in1_ready_pop", 32'(bus.in1_ready), 32'd1);
    tick();
    bus.in1_valid = 1'b0;
    #1;
    check("bp_second", 32'(bus.out_data), 32'h3);
    tick();
    check("bp_third", 32'(bus.out_data), 32'h4);
    tick();

    // Counter saturation (at least five I1 transfers by now).
    check("sat_cnt1", 32'(cnt1), 32'd3);

    // Async reset with two buffered items.
    drive(1'b1, 3'b111, 1'b0, '0, 1'b0);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_cnt1",      32'(cnt1),          32'd0);
    check("arst_in1_ready", 32'(bus.in1_ready), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 3'b001, 1'b1, 3'b010, 1'b1);
    #1;
    check("post_rst_in1_ready", 32'(bus.in1_ready), 32'd1);
    check("post_rst_in0_ready", 32'(bus.in0_ready), 32'd0);
    tick();

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 6), N'($urandom), ($urandom_range(0, 9) < 6),
            N'($urandom), ($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1;
        tick();
        #2;
        rst = 1'b0;
      end
      tick();
    end

    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_stage.md
# mux_arb_stage

Arbitrated source stage for the 3-bit 2:1 data multiplexer path. Accepts two independent (N+1)-bit input channels with valid/ready handshakes and decides each cycle which channel the mux selects. The winner is written into a 2-entry output buffer, so the block both generates the select and registers the muxed result for the next stage. Per-channel grant counters provide observability for lab benches.

## Interface
Parameters:
- N, 2, data MSB index; all data buses are [N:0] (3 bits at default)
- CW, 8, width of each grant counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in1_valid  input  1  channel 1 (I1) has data
- in1_data  input  N+1  channel 1 data
- in1_ready  output  1  channel 1 accepted this cycle when high with in1_valid
- in0_valid  input  1  channel 0 (I0) has data
- in0_data  input  N+1  channel 0 data
- in0_ready  output  1  channel 0 accepted this cycle when high with in0_valid
- sel  output  1  registered: channel of the most recent accepted transfer (1 = I1, 0 = I0)
- out_valid  output  1  buffer head is valid
- out_data  output  N+1  buffer head data
- out_ready  input  1  downstream consumes head when high with out_valid
- cnt1  output  CW  number of accepted channel-1 transfers, saturating
- cnt0  output  CW  number of accepted channel-0 transfers, saturating

## Operation
- Buffer: 2-entry FIFO (rd_ptr, wr_ptr, 2-bit count). out_valid = (count != 0); out_data = entry at rd_ptr.
- pop = out_valid & out_ready. space = (count < 2) | pop (same-cycle pop frees a slot).
- Arbitration is combinational from in1_valid, in0_valid and the priority register pri (1 = I1 preferred):
  - only one channel valid -> that channel wins
  - both valid -> channel equal to pri wins
  - neither valid -> no grant
- inX_ready = space & (X is winner). The loser's ready is 0. ready depends on valid (no combinational loop is permitted downstream: out_ready must not depend on inX_ready).
- push = granted channel's valid & ready. On push: winner's data written at wr_ptr, sel <= winner, pri <= ~winner, winner's counter increments unless already all-ones.
- No push: sel, pri and counters hold.
- Simultaneous push and pop: count unchanged, both pointers advance; valid when count is 1 or 2.
- Push into empty with pop: impossible (pop requires out_valid).
- Pointers wrap modulo 2.

## Timing
- Reset values (asynchronous): out_valid 0, count 0, rd_ptr 0, wr_ptr 0, sel 0, pri 1, cnt1 0, cnt0 0. out_data is don't-care while out_valid is 0; storage is not required to reset.
- inX_ready is combinational. It is 0 during reset.
- Latency: data accepted at edge t appears on out_data with out_valid high after edge t (visible cycle t+1) when the buffer was empty.
- Throughput: 1 transfer/cycle sustained with out_ready held high.
- With out_ready low, at most 2 transfers are accepted. Both readies then stay 0 until a pop.
- Reset asserted mid-stream: the buffer is emptied immediately, buffered data is discarded, and counters clear. After deassertion the first grant with both channels valid goes to I1.

## Configuration
- MUX_ARB_RR_EN defined: round-robin as described (pri toggles to the loser after every push).
- MUX_ARB_RR_EN undefined: fixed priority. I1 always wins when both channels are valid, and pri is held constant at 1. sel, the counters and the buffer behave identically.

## Test plan
- Reset then idle: rst=1 for 2 cycles, both valids 0 -> out_valid=0, sel=0, cnt1=cnt0=0, in1_ready=in0_ready=0 after release.
- Single channel: in0_valid=1 with data 001, out_ready=1 -> in0_ready=1; next cycle out_data=001, out_valid=1, sel=0, cnt0=1.
- Contention (RR_EN defined): both valid continuously with in1=110, in0=101, out_ready=1 -> output sequence 110,101,110,101; sel toggles 1,0,1,0; cnt1=cnt0=2 after 4 cycles.
- Contention (RR_EN undefined): same stimulus -> output 110 every cycle; cnt1=4, cnt0=0.
- Backpressure: out_ready=0, in1 valid with 010 then 011 -> both accepted, count=2, in1_ready=0 on the third cycle. Raise out_ready -> 010 then 011 delivered in order, and a third item is accepted in the same cycle as the first pop.
- Saturation and reset: CW=2, drive 5 channel-1 transfers -> cnt1 stops at 3. Assert rst with 2 buffered items -> out_valid=0 and cnt1=0 immediately, without waiting for a clock edge.
